// File: rtl/tmds_channel_decoder_if.sv
// TMDS channel decoder bus: raw deserialized word in, decoded pixel/control out.
// The master side feeds raw 10-bit words and consumes the decoded stream;
// the slave side is the decoder itself.
interface tmds_channel_decoder_if;
    logic [9:0] tmds_i;     // raw word, bit 0 is the first serial bit
    logic [7:0] data_o;     // decoded pixel byte
    logic [1:0] ctrl_o;     // {c1,c0} from the last control token
    logic       de_o;       // data_o valid this cycle
    logic       locked_o;   // word alignment achieved
    logic [3:0] offset_o;   // current bit-slip offset, 0..9

    modport master (
        output tmds_i,
        input  data_o,
        input  ctrl_o,
        input  de_o,
        input  locked_o,
        input  offset_o
    );

    modport slave (
        input  tmds_i,
        output data_o,
        output ctrl_o,
        output de_o,
        output locked_o,
        output offset_o
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: recovers word alignment by bit-slipping until a run of
// RUN_TOKENS aligned control tokens is seen, then decodes control tokens to
// {c1,c0} and data words to 8-bit pixel values.
// Optional macro TMDS_RELOCK_EN: when defined, a locked channel that sees no
// qualifying blanking run for TIMEOUT_CYCLES cycles drops back to search,
// keeping its current offset. When undefined, lock is sticky until reset.
module tmds_channel_decoder #(
    parameter int RUN_TOKENS     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n_i,
    tmds_channel_decoder_if.slave bus
);
    localparam int RUN_W = $clog2(RUN_TOKENS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_TOKENS);
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(RUN_TOKENS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic             locked_q;
    logic [3:0]       offset_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] run_cnt_d;
    logic [TMR_W-1:0] timer_q;
    logic [9:0]       prev_q;

    logic [7:0]       data_q;
    logic [1:0]       ctrl_q;
    logic             de_q;

    logic [19:0]      window;
    logic [9:0]       word;
    logic             is_ctrl;
    logic [1:0]       ctrl_val;
    logic [7:0]       word_lo;
    logic [7:0]       dec_data;
    logic             run_done;
    logic             timeout;

    // Previous word is the low half of the alignment window.
    assign window = {bus.tmds_i, prev_q};
    assign word   = 10'(window >> offset_q);

    // Recognise the four DVI control tokens in the aligned word.
    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'b00;
        case (word)
            10'b1101010100: ctrl_val = 2'b00;
            10'b0010101011: ctrl_val = 2'b01;
            10'b0101010100: ctrl_val = 2'b10;
            10'b1010101011: ctrl_val = 2'b11;
            default:        is_ctrl  = 1'b0;
        endcase
    end

    // Data decode: undo the optional inversion, then the XOR/XNOR chain.
    assign word_lo     = word[9] ? ~word[7:0] : word[7:0];
    assign dec_data[0] = word_lo[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign dec_data[gi] = word[8] ? (word_lo[gi] ^ word_lo[gi-1])
                                          : ~(word_lo[gi] ^ word_lo[gi-1]);
        end
    endgenerate

    // Run-length of aligned control tokens, saturating; run_done fires only
    // on the cycle the count first reaches RUN_TOKENS.
    always_comb begin
        run_cnt_d = '0;
        if (is_ctrl) begin
            run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
        end
    end
    assign run_done = is_ctrl && (run_cnt_q == RUN_PRE);
    assign timeout  = (timer_q == TMR_LAST);

    // Alignment FSM: slip while searching, freeze offset once locked.
    always_ff @(posedge clk_pixel or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_SEARCH;
            locked_q  <= 1'b0;
            offset_q  <= 4'd0;
            run_cnt_q <= '0;
            timer_q   <= '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (run_done) begin
                        state_q   <= ST_LOCKED;
                        locked_q  <= 1'b1;
                        run_cnt_q <= run_cnt_d;
                        timer_q   <= '0;
                    end else if (timeout) begin
                        offset_q  <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                        run_cnt_q <= '0;
                        timer_q   <= '0;
                    end else begin
                        run_cnt_q <= run_cnt_d;
                        timer_q   <= timer_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
`ifdef TMDS_RELOCK_EN
                    if (run_done) begin
                        run_cnt_q <= run_cnt_d;
                        timer_q   <= '0;
                    end else if (timeout) begin
                        state_q   <= ST_SEARCH;
                        locked_q  <= 1'b0;
                        run_cnt_q <= '0;
                        timer_q   <= '0;
                    end else begin
                        run_cnt_q <= run_cnt_d;
                        timer_q   <= timer_q + 1'b1;
                    end
`else
                    run_cnt_q <= run_cnt_d;
                    timer_q   <= '0;
`endif
                end
                default: begin
                    state_q   <= ST_SEARCH;
                    locked_q  <= 1'b0;
                    run_cnt_q <= '0;
                    timer_q   <= '0;
                end
            endcase
        end
    end

    // Capture the raw word for the next cycle's window.
    always_ff @(posedge clk_pixel or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= bus.tmds_i;
        end
    end

    // Registered output stage, gated by the lock status of this cycle.
    always_ff @(posedge clk_pixel or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else if (!locked_q) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else if (is_ctrl) begin
            data_q <= '0;
            ctrl_q <= ctrl_val;
            de_q   <= 1'b0;
        end else begin
            data_q <= dec_data;
            de_q   <= 1'b1;
        end
    end

    assign bus.data_o   = data_q;
    assign bus.ctrl_o   = ctrl_q;
    assign bus.de_o     = de_q;
    assign bus.locked_o = locked_q;
    assign bus.offset_o = offset_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomized bench for tmds_channel_decoder against a serial-stream reference
// model (RUN_TOKENS=8, TIMEOUT_CYCLES=64).
module tb_tmds_channel_decoder;
    localparam int RUN_TOKENS     = 8;
    localparam int TIMEOUT_CYCLES = 64;

    logic clk_pixel = 1'b0;
    logic reset_n   = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .RUN_TOKENS     (RUN_TOKENS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset_n_i (reset_n),
        .bus       (bus.slave)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Reference model state
    logic [9:0] m_prev;
    int         m_run;      // consecutive aligned tokens, unbounded
    int         m_idle;     // cycles since last qualifying event
    bit         m_locked;
    int         m_off;
    logic [7:0] e_data;
    logic [1:0] e_ctrl;
    bit         e_de;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int token_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] b;
        logic [7:0] d;
        b    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++) d[i] = b[i] ^ b[i-1] ^ ~w[8];
        return d;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (token_code(w) >= 0);
        return w;
    endfunction

    task automatic m_reset();
        m_prev = '0; m_run = 0; m_idle = 0; m_locked = 0; m_off = 0;
        e_data = '0; e_ctrl = '0; e_de = 0;
    endtask

    // One clock edge of the reference: pick ten consecutive serial bits
    // starting m_off bits into the previous word.
    task automatic m_step(input logic [9:0] word);
        logic [9:0] a;
        int tk;
        for (int j = 0; j < 10; j++)
            a[j] = (m_off + j < 10) ? m_prev[m_off + j] : word[m_off + j - 10];
        tk = token_code(a);
        if (!m_locked) begin
            e_de = 0; e_data = 0; e_ctrl = 0;
        end else if (tk >= 0) begin
            e_de = 0; e_data = 0; e_ctrl = 2'(tk);
        end else begin
            e_de = 1; e_data = tmds_decode(a);
        end
        m_run = (tk >= 0) ? m_run + 1 : 0;
        if (!m_locked) begin
            if (m_run == RUN_TOKENS) begin
                m_locked = 1; m_idle = 0;
            end else if (m_idle == TIMEOUT_CYCLES - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_idle = 0;
            end else m_idle++;
        end else begin
`ifdef TMDS_RELOCK_EN
            if (m_run == RUN_TOKENS) m_idle = 0;
            else if (m_idle == TIMEOUT_CYCLES - 1) begin
                m_locked = 0; m_run = 0; m_idle = 0;
            end else m_idle++;
`endif
        end
        m_prev = word;
    endtask

    // Drive one word, advance one clock, compare on the falling edge.
    task automatic cycle(input logic [9:0] word);
        bus.tmds_i = word;
        @(posedge clk_pixel);
        m_step(word);
        @(negedge clk_pixel);
        check_eq("de",     int'(bus.de_o),     int'(e_de));
        check_eq("data",   int'(bus.data_o),   int'(e_data));
        check_eq("ctrl",   int'(bus.ctrl_o),   int'(e_ctrl));
        check_eq("locked", int'(bus.locked_o), int'(m_locked));
        check_eq("offset", int'(bus.offset_o), m_off);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_de"},     int'(bus.de_o),     0);
        check_eq({tag, "_data"},   int'(bus.data_o),   0);
        check_eq({tag, "_ctrl"},   int'(bus.ctrl_o),   0);
        check_eq({tag, "_locked"}, int'(bus.locked_o), 0);
        check_eq({tag, "_offset"}, int'(bus.offset_o), 0);
    endtask

    initial begin
        logic [9:0] tok [4];
        logic [9:0] carry;
        logic [9:0] refw;
        int         t;
        tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;

        bus.tmds_i = '0;
        m_reset();
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk_pixel);
        reset_n = 1'b1;

        // Aligned stream: 12 tokens, directed data, a control change, then
        // random blanking/active lines.
        for (int i = 0; i < 12; i++) cycle(10'h354);
        cycle(10'h100); cycle(10'h2FF); cycle(10'h0FF);
        cycle(10'h0AB); cycle(rand_data()); cycle(rand_data());
        cycle(rand_data());
        check_eq("t3_ctrl_held", int'(bus.ctrl_o), 1);
        for (int l = 0; l < 10; l++) begin
            t = $urandom_range(0, 3);
            for (int i = $urandom_range(8, 14); i > 0; i--) cycle(tok[t]);
            for (int i = $urandom_range(10, 40); i > 0; i--) cycle(rand_data());
        end
        check_eq("aligned_locked", int'(bus.locked_o), 1);

        // No blanking for longer than the timeout.
        for (int i = 0; i < 80; i++) cycle(rand_data());
`ifdef TMDS_RELOCK_EN
        check_eq("t6_locked", int'(bus.locked_o), 0);
`else
        check_eq("t6_locked", int'(bus.locked_o), 1);
`endif
        check_eq("t6_offset", int'(bus.offset_o), 0);

        // Clean restart.
        reset_n = 1'b0;
        repeat (3) @(negedge clk_pixel);
        m_reset();
        check_zero("reset2");
        reset_n = 1'b1;

        // Words shifted by 3 bits: each aligned word starts at prev bit 3.
        carry = '0;
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 40; i++) begin
                refw = (i < 12) ? 10'h354 : rand_data();
                cycle({refw[6:0], carry[2:0]});
                carry = {7'd0, refw[9:7]};
            end
        end
        check_eq("t4_locked", int'(bus.locked_o), 1);
        check_eq("t4_offset", int'(bus.offset_o), 3);

        // Asynchronous reset mid-cycle while locked.
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        m_reset();
        @(negedge clk_pixel);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) cycle(10'h2AB);
        for (int i = 0; i < 10; i++) cycle(rand_data());
        check_eq("relock_locked", int'(bus.locked_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
